// File: rtl/sprite_mask_buffer.sv
// Sprite opacity mask store: NUM_SPRITES square 1-bit masks looked up by a decoder.
// Define SPRITE_MASK_DOUBLE_BUF_EN for front/back banks with commit/swap handshake; default is a single bank.
module sprite_mask_buffer #(
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_SIZE = 32,
    localparam int IDW = ($clog2(NUM_SPRITES) > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int CW  = ($clog2(SPRITE_SIZE) > 1) ? $clog2(SPRITE_SIZE) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_wr_valid,
    input  logic [IDW-1:0] i_wr_id,
    input  logic [CW-1:0]  i_wr_x,
    input  logic [CW-1:0]  i_wr_y,
    input  logic           i_wr_opacity,
    output logic           o_wr_ready,
    input  logic           i_commit,
    input  logic           i_swap,
    input  logic [IDW-1:0] i_rd_id,
    input  logic [CW-1:0]  i_rd_x,
    input  logic [CW-1:0]  i_rd_y,
    output logic           o_rd_opacity,
    output logic [7:0]     o_frame_count,
    output logic           o_wr_dropped
);

    localparam int DEPTH = NUM_SPRITES * SPRITE_SIZE * SPRITE_SIZE;
    localparam int AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

    logic          wr_in_range;
    logic          rd_in_range;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_bit;
    logic          swap_evt;
    logic          rd_opacity_q;
    logic [7:0]    frame_count_q;

    // Masks are flattened sprite-major, then row, then column.
    always_comb begin
        wr_in_range = (int'(i_wr_id) < NUM_SPRITES) && (int'(i_wr_x) < SPRITE_SIZE)
                   && (int'(i_wr_y) < SPRITE_SIZE);
        rd_in_range = (int'(i_rd_id) < NUM_SPRITES) && (int'(i_rd_x) < SPRITE_SIZE)
                   && (int'(i_rd_y) < SPRITE_SIZE);
        wr_addr = AW'((int'(i_wr_id) * SPRITE_SIZE + int'(i_wr_y)) * SPRITE_SIZE + int'(i_wr_x));
        rd_addr = AW'((int'(i_rd_id) * SPRITE_SIZE + int'(i_rd_y)) * SPRITE_SIZE + int'(i_rd_x));
    end

`ifdef SPRITE_MASK_DOUBLE_BUF_EN

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t state_q;
    logic   bank_ptr_q;
    logic   wr_ready_q;
    logic   wr_dropped_q;
    logic   wr_accept;

    assign wr_accept = i_wr_valid && wr_ready_q && wr_in_range;
    // A commit and swap arriving together while filling behave as if PEND was passed through.
    assign swap_evt  = (state_q == ST_PEND) ? i_swap : (i_commit && i_swap);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            bank_ptr_q   <= 1'b0;
            wr_ready_q   <= 1'b1;
            wr_dropped_q <= 1'b0;
        end else begin
            if (i_wr_valid && !wr_ready_q) begin
                wr_dropped_q <= 1'b1;
            end
            if (swap_evt) begin
                bank_ptr_q <= ~bank_ptr_q;
                state_q    <= ST_IDLE;
                wr_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_commit) begin
                            state_q    <= ST_PEND;
                            wr_ready_q <= 1'b0;
                        end else if (wr_accept) begin
                            state_q <= ST_FILL;
                        end
                    end
                    ST_FILL: begin
                        if (i_commit) begin
                            state_q    <= ST_PEND;
                            wr_ready_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= ST_PEND;
                        wr_ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The bank leaving the front is wiped on the swap edge so the next frame starts blank.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [DEPTH-1:0] mem_q;
        logic             clr;
        logic             we;

        assign clr = swap_evt && (bank_ptr_q == 1'(gi));
        assign we  = wr_accept && (bank_ptr_q != 1'(gi));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                mem_q <= '0;
            end else if (clr) begin
                mem_q <= '0;
            end else if (we) begin
                mem_q[wr_addr] <= i_wr_opacity;
            end
        end
    end

    assign rd_bit       = bank_ptr_q ? g_bank[1].mem_q[rd_addr] : g_bank[0].mem_q[rd_addr];
    assign o_wr_ready   = wr_ready_q;
    assign o_wr_dropped = wr_dropped_q;

`else

    logic [DEPTH-1:0] mem_q;
    logic             unused_commit;

    assign unused_commit = i_commit;
    assign swap_evt      = i_swap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q <= '0;
        end else if (i_wr_valid && wr_in_range) begin
            mem_q[wr_addr] <= i_wr_opacity;
        end
    end

    assign rd_bit       = mem_q[rd_addr];
    assign o_wr_ready   = 1'b1;
    assign o_wr_dropped = 1'b0;

`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_opacity_q  <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            rd_opacity_q <= rd_in_range ? rd_bit : 1'b0;
            if (swap_evt) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    assign o_rd_opacity  = rd_opacity_q;
    assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_sprite_mask_buffer.sv
// Bench for sprite_mask_buffer; odd sizes make out-of-range ids/coordinates representable.
`timescale 1ns/1ps
module tb_sprite_mask_buffer;

    localparam int NS  = 3;
    localparam int SZ  = 24;
    localparam int IDW = 2;
    localparam int CW  = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_valid;
    logic [IDW-1:0] wr_id;
    logic [CW-1:0]  wr_x, wr_y;
    logic           wr_op;
    logic           wr_ready;
    logic           commit, swap;
    logic [IDW-1:0] rd_id;
    logic [CW-1:0]  rd_x, rd_y;
    logic           rd_op;
    logic [7:0]     frame_count;
    logic           wr_dropped;

    always #5 clk = ~clk;

    sprite_mask_buffer #(.NUM_SPRITES(NS), .SPRITE_SIZE(SZ)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_valid(wr_valid), .i_wr_id(wr_id), .i_wr_x(wr_x), .i_wr_y(wr_y),
        .i_wr_opacity(wr_op), .o_wr_ready(wr_ready),
        .i_commit(commit), .i_swap(swap),
        .i_rd_id(rd_id), .i_rd_x(rd_x), .i_rd_y(rd_y),
        .o_rd_opacity(rd_op), .o_frame_count(frame_count), .o_wr_dropped(wr_dropped)
    );

    // Reference: mem_m[bank][sprite][row][col]; single-bank builds only use bank 0.
    bit mem_m [2][NS][SZ][SZ];
    int ptr_m, fc_m;
    bit pend_m, drop_m, exp_rd, exp_ready;
    int checks = 0;
    int errors = 0;

    function automatic bit in_rng(int id, int x, int y);
        return (id < NS) && (x < SZ) && (y < SZ);
    endfunction

    task automatic model_reset();
        foreach (mem_m[b, i, y, x]) mem_m[b][i][y][x] = 1'b0;
        ptr_m = 0; fc_m = 0; pend_m = 1'b0; drop_m = 1'b0;
        exp_rd = 1'b0; exp_ready = 1'b1;
    endtask

    task automatic idle_in();
        wr_valid = 1'b0; commit = 1'b0; swap = 1'b0;
    endtask

    task automatic set_wr(int id, int x, int y, bit op);
        wr_valid = 1'b1; wr_id = IDW'(id); wr_x = CW'(x); wr_y = CW'(y); wr_op = op;
    endtask

    task automatic set_rd(int id, int x, int y);
        rd_id = IDW'(id); rd_x = CW'(x); rd_y = CW'(y);
    endtask

    // One clock: predict outputs from the current inputs, then advance to just past the edge.
    task automatic cycle();
        bit rd_e, sw;
        int wid, wx, wy, rid, rx, ry;
        wid = int'(wr_id); wx = int'(wr_x); wy = int'(wr_y);
        rid = int'(rd_id); rx = int'(rd_x); ry = int'(rd_y);
        rd_e = in_rng(rid, rx, ry) ? mem_m[ptr_m][rid][ry][rx] : 1'b0;
`ifdef SPRITE_MASK_DOUBLE_BUF_EN
        if (wr_valid && pend_m) drop_m = 1'b1;
        if (wr_valid && !pend_m && in_rng(wid, wx, wy)) mem_m[1-ptr_m][wid][wy][wx] = wr_op;
        sw = pend_m ? swap : (commit && swap);
        if (sw) begin
            for (int i = 0; i < NS; i++)
                for (int y = 0; y < SZ; y++)
                    for (int x = 0; x < SZ; x++) mem_m[ptr_m][i][y][x] = 1'b0;
            ptr_m  = 1 - ptr_m;
            fc_m   = (fc_m + 1) % 256;
            pend_m = 1'b0;
        end else if (!pend_m && commit) begin
            pend_m = 1'b1;
        end
`else
        sw = swap;
        if (wr_valid && in_rng(wid, wx, wy)) mem_m[0][wid][wy][wx] = wr_op;
        if (sw) fc_m = (fc_m + 1) % 256;
`endif
        @(posedge clk); #1;
        exp_rd    = rd_e;
        exp_ready = !pend_m;
    endtask

    task automatic apply_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_in(); set_rd(0, 0, 0); wr_id = '0; wr_x = '0; wr_y = '0; wr_op = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", rd_op); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", frame_count); end
        checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", wr_dropped); end
        rst_n = 1'b1;
        model_reset();
        cycle();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_ready); end
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL reset_rd0 got %b want 0", rd_op); end
        $display("test_reset done");
    endtask

    task automatic test_write_visible();
        set_wr(1, 5, 5, 1'b1); set_rd(1, 5, 5);
        cycle();
        checks++; if (rd_op !== exp_rd) begin errors++; $display("FAIL same_cycle_rd got %b want %b", rd_op, exp_rd); end
        idle_in();
        cycle();
        checks++; if (rd_op !== exp_rd) begin errors++; $display("FAIL write_then_rd got %b want %b", rd_op, exp_rd); end
        $display("test_write_visible rd=%b exp=%b", rd_op, exp_rd);
    endtask

    task automatic test_out_of_range();
        // x=24,y=2 on sprite 0 and x=0,y=24 would alias (0,3) and sprite 1 (0,0) if unchecked.
        set_wr(0, 24, 2, 1'b1); cycle();
        set_wr(0, 0, 24, 1'b1); cycle();
        set_wr(3, 0, 0, 1'b1);  cycle();
        idle_in();
        checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL oor_drop got %b want 0", wr_dropped); end
        set_rd(0, 0, 3); cycle();
        checks++; if (rd_op !== exp_rd) begin errors++; $display("FAIL oor_alias_x got %b want %b", rd_op, exp_rd); end
        set_rd(1, 0, 0); cycle();
        checks++; if (rd_op !== exp_rd) begin errors++; $display("FAIL oor_alias_y got %b want %b", rd_op, exp_rd); end
        set_wr(0, 0, 3, 1'b1); cycle();
        idle_in();
        set_rd(0, 24, 2); cycle();
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL oor_read got %b want 0", rd_op); end
        set_rd(0, 0, 3); cycle();
        checks++; if (rd_op !== exp_rd) begin errors++; $display("FAIL inrange_read got %b want %b", rd_op, exp_rd); end
        $display("test_out_of_range drop=%b", wr_dropped);
    endtask

    task automatic test_random(int n);
        int span;
        for (int k = 0; k < n; k++) begin
            span = ($urandom_range(0, 7) == 0) ? 31 : 9;
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_id = IDW'($urandom_range(0, 3));
            wr_x  = CW'($urandom_range(0, span));
            wr_y  = CW'($urandom_range(0, span));
            wr_op = ($urandom_range(0, 3) != 0);
            commit = ($urandom_range(0, 19) == 0);
            swap   = ($urandom_range(0, 15) == 0);
            rd_id = IDW'($urandom_range(0, 3));
            rd_x  = CW'($urandom_range(0, span));
            rd_y  = CW'($urandom_range(0, span));
            cycle();
            checks++; if (rd_op !== exp_rd) begin errors++; $display("FAIL rand_rd[%0d] got %b want %b", k, rd_op, exp_rd); end
            checks++; if (frame_count !== 8'(fc_m)) begin errors++; $display("FAIL rand_fc[%0d] got %0d want %0d", k, frame_count, fc_m); end
            checks++; if (wr_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", k, wr_ready, exp_ready); end
            checks++; if (wr_dropped !== drop_m) begin errors++; $display("FAIL rand_drop[%0d] got %b want %b", k, wr_dropped, drop_m); end
        end
        idle_in();
        $display("test_random cycles=%0d fc=%0d", n, frame_count);
    endtask

    task automatic test_frame_wrap();
        apply_reset();
        for (int k = 1; k <= 256; k++) begin
            commit = 1'b1; cycle(); commit = 1'b0;
            swap = 1'b1;   cycle(); swap = 1'b0;
            if (k == 1 || k == 255 || k == 256) begin
                checks++;
                if (frame_count !== 8'(k % 256)) begin
                    errors++; $display("FAIL wrap_fc[%0d] got %0d want %0d", k, frame_count, k % 256);
                end
            end
        end
        $display("test_frame_wrap fc=%0d", frame_count);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        swap = 1'b1; commit = 1'b1; cycle(); idle_in();
        set_wr(2, 7, 7, 1'b1); cycle();
        set_wr(0, 1, 2, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL midrst_rd got %b want 0", rd_op); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL midrst_fc got %0d want 0", frame_count); end
        checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL midrst_drop got %b want 0", wr_dropped); end
        idle_in();
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", wr_ready); end
        commit = 1'b1; swap = 1'b1; cycle(); idle_in();
        set_rd(2, 7, 7); cycle();
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL midrst_rd_a got %b want 0", rd_op); end
        set_rd(0, 1, 2); cycle();
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL midrst_rd_b got %b want 0", rd_op); end
        $display("test_reset_mid fc=%0d", frame_count);
    endtask

`ifdef SPRITE_MASK_DOUBLE_BUF_EN
    task automatic test_double_buffer();
        apply_reset();
        set_wr(1, 3, 4, 1'b1); cycle(); idle_in();
        commit = 1'b1; cycle(); commit = 1'b0;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL pend_ready got %b want 0", wr_ready); end
        set_rd(1, 3, 4); cycle();
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL pre_swap_rd got %b want 0", rd_op); end
        set_wr(0, 2, 2, 1'b1); cycle(); idle_in();
        checks++; if (wr_dropped !== 1'b1) begin errors++; $display("FAIL pend_drop got %b want 1", wr_dropped); end
        swap = 1'b1; cycle(); swap = 1'b0;
        checks++; if (rd_op !== 1'b0) begin errors++; $display("FAIL swap_cycle_rd got %b want 0", rd_op); end
        cycle();
        checks++; if (rd_op !== 1'b1) begin errors++; $display("FAIL post_swap_rd got %b want 1", rd_op); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL post_swap_fc got %0d want 1", frame_count); end
        swap = 1'b1; cycle(); swap = 1'b0; cycle();
        checks++; if (rd_op !== 1'b1) begin errors++; $display("FAIL nocommit_rd got %b want 1", rd_op); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL nocommit_fc got %0d want 1", frame_count); end
        $display("test_double_buffer fc=%0d drop=%b", frame_count, wr_dropped);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_in();
        test_reset();
        test_write_visible();
        test_out_of_range();
`ifdef SPRITE_MASK_DOUBLE_BUF_EN
        test_double_buffer();
`endif
        test_random(600);
        test_frame_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
